shift_serializer: RTL
=====================

Name: shift_serializer

Overview:
- Transmit end of the 8-bit serial shift link.
- Accepts a parallel word over a valid/ready handshake and shifts it out one bit per clock on sdo.
- Drives the far-end universal shift register's 2-bit mode select (A1,A0), so the word lands intact in its Q outputs via the DL or DR serial input.
- Sits between the word source and the link pins.

Parameters:
- WIDTH, 8, data word width in bits (≥2).
- GAP_CYCLES, 1, idle cycles after each frame with sframe=0 and mode=00 (0 allowed).

Ports:
- clock  input  1  single system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-low reset; sampled on rising edge of clock.
- tx_data  input  WIDTH  word to send.
- tx_valid  input  1  source has a word.
- dir  input  1  captured with word: 0 = MSB first (receiver fills via DL, mode 10); 1 = LSB first (receiver fills via DR, mode 01).
- tx_ready  output  1  block can accept a word this cycle.
- sdo  output  1  serial data to receiver DL/DR.
- sframe  output  1  high while sdo carries a frame bit.
- mode  output  2  {A1,A0} for the receiver: 00 hold, 10 shift-in via DL, 01 shift-in via DR.
- done  output  1  one-cycle pulse after the last frame bit.

Behaviour:
- All outputs are registered.
- Reset values (reset=0 at an edge): state IDLE, tx_ready=1, sdo=0, sframe=0, mode=00, done=0, bit counter=0, shift register=0.
- Reset mid-frame aborts the frame. The word is dropped; the next edge with reset=1 behaves as IDLE.
- States: IDLE, SHIFT, (PARITY), GAP.
- IDLE:
  - tx_ready=1.
  - Handshake fires when tx_valid=1 and tx_ready=1 at an edge: tx_data and dir are captured, then → SHIFT.
  - tx_valid with tx_ready=0 is ignored. Source must hold data until accepted.
- SHIFT:
  - Lasts exactly WIDTH cycles; tx_ready=0, sframe=1.
  - mode=10 if dir=0, 01 if dir=1.
  - Cycle i (i=0..WIDTH-1) presents bit WIDTH-1-i (dir=0) or bit i (dir=1).
  - The receiver samples sdo/mode at the edge ending each cycle.
  - The first frame bit appears in the cycle immediately after the accept edge (latency 1).
  - tx_data and dir changes during SHIFT have no effect.
- After the last bit:
  - → GAP if GAP_CYCLES>0, else → IDLE.
  - done=1 for exactly the first cycle after the final frame bit; sframe=0, mode=00, sdo=0.
- GAP:
  - Lasts GAP_CYCLES cycles; tx_ready=0.
  - The cycle after GAP has tx_ready=1.
- Back-to-back with GAP_CYCLES=0: tx_ready=1 in the done cycle. A word accepted at that edge starts its frame the next cycle; zero bubbles beyond the done cycle.
- Bit counter width is clog2(WIDTH+1). It counts 0..WIDTH-1 and never wraps inside a frame.
- Receiver contract: after the frame, with mode=00 on the link, receiver Q[k] equals sent tx_data[k] for either dir.

Optional Feature:
- Macro: SHIFT_SERIALIZER_PARITY_EN.
- Defined:
  - A PARITY state follows SHIFT for one cycle: sframe=1, mode=00 (receiver holds), sdo = XOR of all WIDTH captured bits (even parity).
  - done moves one cycle later; frame length is WIDTH+1.
- Undefined: no PARITY state; frame length is WIDTH; sframe never high while mode=00.

Test Plan:
- Reset: hold reset=0 for 2 cycles mid-frame, then release → outputs tx_ready=1, sdo=0, sframe=0, mode=00, done=0. A new word 0x3C is then sent correctly.
- MSB first: tx_data=0xA5, dir=0, GAP_CYCLES=1 → sdo 1,0,1,0,0,1,0,1 over cycles 1-8 with mode=10, sframe=1. done in cycle 9; tx_ready=1 in cycle 11. Modelled receiver Q7..Q0=10100101.
- LSB first: tx_data=0x81, dir=1 → sdo 1,0,0,0,0,0,0,1 with mode=01. Receiver Q=0x81.
- Back-to-back: GAP_CYCLES=0, tx_valid held high with 0x0F then 0xF0 → frames separated by exactly one done cycle. Both received intact. tx_data change mid-frame has no effect.
- Stall: tx_valid=1 during SHIFT → no second accept until tx_ready=1. The word is accepted exactly once.
- Parity (macro defined): tx_data=0x07, dir=0 → 8 data bits, then a 9th cycle with sdo=1, mode=00, sframe=1. done in cycle 10. Receiver Q=0x07.

Source files
------------

// File: rtl/shift_serializer.sv
// Transmit end of the serial shift link: accepts a parallel word on valid/ready and
// shifts it out on sdo while driving the far-end shift register mode. Option: SHIFT_SERIALIZER_PARITY_EN.
module shift_serializer #(
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  input  logic             dir,
  output logic             tx_ready,
  output logic             sdo,
  output logic             sframe,
  output logic [1:0]       mode,
  output logic             done,
  output logic [1:0]       state_dbg
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int GW = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);

  // Handshake: a word is taken at a rising edge where tx_valid and tx_ready are both 1;
  // the source must hold tx_data/dir stable until then, and nothing is sampled otherwise.
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2, GAP = 2'd3} state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [GW-1:0]    gap_cnt, gap_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic             dir_q, dir_n;
  logic             par_q, par_n;
  logic             ready_n, sdo_n, sframe_n, done_n;
  logic [1:0]       mode_n;
  logic             finish;

  assign state_dbg = state;

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    gap_n    = gap_cnt;
    shreg_n  = shreg;
    dir_n    = dir_q;
    par_n    = par_q;
    ready_n  = 1'b0;
    sdo_n    = 1'b0;
    sframe_n = 1'b0;
    mode_n   = 2'b00;
    done_n   = 1'b0;
    finish   = 1'b0;

    case (state)
      IDLE: begin
        ready_n = 1'b1;
        if (tx_valid && tx_ready) begin
          // Outputs are registered, so the first bit is loaded straight from tx_data.
          shreg_n  = tx_data;
          dir_n    = dir;
          par_n    = ^tx_data;
          cnt_n    = '0;
          state_n  = SHIFT;
          ready_n  = 1'b0;
          sframe_n = 1'b1;
          mode_n   = dir ? 2'b01 : 2'b10;
          sdo_n    = dir ? tx_data[0] : tx_data[WIDTH-1];
        end
      end
      SHIFT: begin
        if (cnt == CW'(WIDTH - 1)) begin
`ifdef SHIFT_SERIALIZER_PARITY_EN
          state_n  = PARITY;
          sframe_n = 1'b1;
          sdo_n    = par_q;
`else
          finish   = 1'b1;
`endif
        end else begin
          cnt_n    = cnt + 1'b1;
          shreg_n  = dir_q ? (shreg >> 1) : (shreg << 1);
          sdo_n    = dir_q ? shreg[1] : shreg[WIDTH-2];
          sframe_n = 1'b1;
          mode_n   = dir_q ? 2'b01 : 2'b10;
        end
      end
      PARITY: finish = 1'b1;
      GAP: begin
        // The done cycle is the first GAP cycle; GAP_CYCLES idle cycles follow it.
        if (gap_cnt == GW'(GAP_CYCLES)) begin
          state_n = IDLE;
          ready_n = 1'b1;
        end else begin
          gap_n = gap_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    if (finish) begin
      done_n = 1'b1;
      cnt_n  = '0;
      gap_n  = '0;
      if (GAP_CYCLES > 0) begin
        state_n = GAP;
        ready_n = 1'b0;
      end else begin
        state_n = IDLE;
        ready_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      gap_cnt  <= '0;
      shreg    <= '0;
      dir_q    <= 1'b0;
      par_q    <= 1'b0;
      tx_ready <= 1'b1;
      sdo      <= 1'b0;
      sframe   <= 1'b0;
      mode     <= 2'b00;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      gap_cnt  <= gap_n;
      shreg    <= shreg_n;
      dir_q    <= dir_n;
      par_q    <= par_n;
      tx_ready <= ready_n;
      sdo      <= sdo_n;
      sframe   <= sframe_n;
      mode     <= mode_n;
      done     <= done_n;
    end
  end

endmodule
